instr_controller: RTL

INSTR_CONTROLLER -- requirements
Module: instr_controller

---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/ctrl_addr_gen.sv | 49 ++++
 rtl/instr_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, FSM states and instruction field positions for instr_controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_LOAD_W  = 4'd1,
        OP_LOAD_A  = 4'd2,
        OP_COMPUTE = 4'd3,
        OP_STORE   = 4'd4,
        OP_HALT    = 4'd5
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int OPC_LSB  = 60;
    localparam int OPC_W    = 4;
    localparam int BASE_LSB = 44;
    localparam int BASE_W   = 16;
    localparam int LEN_LSB  = 32;
    localparam int LEN_FW   = 12;

    function automatic logic is_beat_op(input logic [OPC_W-1:0] opc);
        return (opc == OP_LOAD_W) || (opc == OP_LOAD_A) ||
               (opc == OP_COMPUTE) || (opc == OP_STORE);
    endfunction

endpackage

// File: rtl/ctrl_addr_gen.sv
// rtl/ctrl_addr_gen.sv - beat counter with base+index address and last-beat flag
module ctrl_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        idx_d  = idx_q;
        len_d  = len_q;
        base_d = base_q;
        if (load) begin
            idx_d  = '0;
            len_d  = len;
            base_d = base;
        end else if (step) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            len_q  <= '0;
            base_q <= '0;
        end else begin
            idx_q  <= idx_d;
            len_q  <= len_d;
            base_q <= base_d;
        end
    end

    // Address wraps naturally at 2^ADDR_W.
    assign addr = base_q + ADDR_W'(idx_q);
    assign last = (idx_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/instr_controller.sv
// rtl/instr_controller.sv - decodes 64-bit instructions into per-beat scratchpad/array strobes
module instr_controller #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              array_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              array_load_w,
    output logic              array_load_a,
    output logic              array_compute,
    output logic              array_drain,
    output logic              op_done,
    output logic              busy,
    output logic              halted,
    output logic              illegal_instr
);

    import ctrl_pkg::*;

    state_e            state_q, state_d;
    logic [OPC_W-1:0]  op_q, op_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;

    logic [OPC_W-1:0]  opc_in;
    logic [BASE_W-1:0] base_in;
    logic [LEN_FW-1:0] len_in;
    logic              handshake;
    logic              beat;
    logic              gen_load;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic              unused_ok;

    assign opc_in    = instr_in[OPC_LSB +: OPC_W];
    assign base_in   = instr_in[BASE_LSB +: BASE_W];
    assign len_in    = instr_in[LEN_LSB +: LEN_FW];
    assign unused_ok = ^instr_in[31:0];

    // Gated with rst so the handshake is refused while reset is held.
    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign handshake   = instr_valid && instr_ready;
    assign beat        = (state_q == ST_EXEC) && array_ready;
    assign busy        = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign illegal_instr = illegal_q;

    ctrl_addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (gen_load),
        .base (ADDR_W'(base_in)),
        .len  (LEN_W'(len_in)),
        .step (beat),
        .addr (gen_addr),
        .last (gen_last)
    );

    always_comb begin
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        array_load_w  = 1'b0;
        array_load_a  = 1'b0;
        array_compute = 1'b0;
        array_drain   = 1'b0;
        if (beat) begin
            case (op_q)
                OP_LOAD_W:  begin mem_rd_en = 1'b1; array_load_w = 1'b1; end
                OP_LOAD_A:  begin mem_rd_en = 1'b1; array_load_a = 1'b1; end
                OP_COMPUTE: array_compute = 1'b1;
                OP_STORE:   begin mem_wr_en = 1'b1; array_drain = 1'b1; end
                default:    ;
            endcase
        end
    end

    // Compute beats and idle cycles keep presenting the last memory address.
    always_comb begin
        mem_addr    = (mem_rd_en || mem_wr_en) ? gen_addr : addr_hold_q;
        addr_hold_d = mem_addr;
        op_done     = done_q || (beat && gen_last);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        gen_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (opc_in == OP_HALT) begin
                        state_d = ST_HALT;
                    end else if (is_beat_op(opc_in) && (len_in != '0)) begin
                        state_d  = ST_EXEC;
                        op_d     = opc_in;
                        gen_load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (opc_in > OP_HALT) begin
                            illegal_d = 1'b1;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (beat && gen_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            addr_hold_q <= addr_hold_d;
        end
    end

endmodule
